// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with brightness PWM, leading-zero blanking
// and frame-aligned (tear-free) loading of the displayed value.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100000,
  parameter int PWM_BITS     = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic                    load_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic                    blank_lz_in,
  input  logic [PWM_BITS-1:0]     bright_in,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              seg_out,
  output logic                    frame_done_out
);

  localparam int TIMER_W = $clog2(COUNT_PERIOD);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [TIMER_W-1:0] TC_VAL    = TIMER_W'(COUNT_PERIOD - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);

  // Active-low gfedcba pattern for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [TIMER_W-1:0]      timer_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] shadow_r;
  logic [4*NUM_DIGITS-1:0] disp_r;
  logic                    wrap_d_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic [6:0]              seg_r;
  logic                    frame_done_r;

  logic                    tc_s;
  logic                    wrap_s;
  logic                    zero_run_s;
  logic [3:0]              nib_s [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_s;
  logic [3:0]              cur_nib_s;
  logic                    duty_s;
  logic                    lit_s;
  logic [NUM_DIGITS-1:0]   an_nxt_s;
  logic [6:0]              seg_nxt_s;

  // Slot timing, leading-zero mask, PWM gate and next output pattern
  always_comb begin
    tc_s       = (timer_r == TC_VAL);
    wrap_s     = tc_s && (idx_r == LAST_IDX);
    zero_run_s = 1'b1;
    lz_s       = {NUM_DIGITS{1'b0}};
    // Walk from the most significant digit so zero_run_s covers nibbles d..top
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      nib_s[d]   = disp_r[4*d +: 4];
      zero_run_s = zero_run_s && (nib_s[d] == 4'h0);
      lz_s[d]    = blank_lz_in && (d != 0) && zero_run_s;
    end
    cur_nib_s = nib_s[idx_r];
    duty_s    = (bright_in == {PWM_BITS{1'b1}}) || (timer_r[PWM_BITS-1:0] < bright_in);
    lit_s     = digit_en_in[idx_r] && !lz_s[idx_r] && duty_s;
    an_nxt_s  = {NUM_DIGITS{1'b1}};
    seg_nxt_s = 7'h7F;
    if (lit_s) begin
      an_nxt_s[idx_r] = 1'b0;
      seg_nxt_s       = hex7(cur_nib_s);
    end else begin
      an_nxt_s  = {NUM_DIGITS{1'b1}};
      seg_nxt_s = 7'h7F;
    end
  end

  // Slot timer and digit index
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      timer_r <= {TIMER_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else if (tc_s) begin
      timer_r <= {TIMER_W{1'b0}};
      idx_r   <= wrap_s ? {IDX_W{1'b0}} : idx_r + IDX_ONE;
    end else begin
      timer_r <= timer_r + TIMER_ONE;
    end
  end

  // Shadow capture; the displayed value only changes at a frame boundary
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shadow_r <= {(4*NUM_DIGITS){1'b0}};
      disp_r   <= {(4*NUM_DIGITS){1'b0}};
    end else begin
      if (load_in) begin
        shadow_r <= val_in;
      end
      if (wrap_s) begin
        disp_r <= load_in ? val_in : shadow_r;
      end
    end
  end

  // Registered pins; frame_done is delayed twice to line up with digit 0 on the pins
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      an_r         <= {NUM_DIGITS{1'b1}};
      seg_r        <= 7'h7F;
      wrap_d_r     <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_nxt_s;
      seg_r        <= seg_nxt_s;
      wrap_d_r     <= wrap_s;
      frame_done_r <= wrap_d_r;
    end
  end

  assign an_out         = an_r;
  assign seg_out        = seg_r;
  assign frame_done_out = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 16-cycle slots, 4-bit PWM.
module tb_seg7_scan_driver;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] val_in;
  logic        load_in;
  logic [3:0]  digit_en_in;
  logic        blank_lz_in;
  logic [3:0]  bright_in;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        frame_done_out;

  int total_cnt = 0;
  int bad_cnt   = 0;

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .COUNT_PERIOD(16),
    .PWM_BITS    (4)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .val_in        (val_in),
    .load_in       (load_in),
    .digit_en_in   (digit_en_in),
    .blank_lz_in   (blank_lz_in),
    .bright_in     (bright_in),
    .an_out        (an_out),
    .seg_out       (seg_out),
    .frame_done_out(frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic load_val(input logic [15:0] v);
    val_in  = v;
    load_in = 1'b1;
    @(negedge clk_in);
    load_in = 1'b0;
  endtask

  // Lands on the negedge where frame_done_out is high (first digit-0 output of a frame)
  task automatic wait_fd();
    for (int i = 0; i < 300; i++) begin
      if (frame_done_out) break;
      @(negedge clk_in);
    end
    check_val("fd_seen", {31'd0, frame_done_out}, 32'd1);
  endtask

  int lit_cnt;
  int multi_cnt;
  int off_cnt;

  initial begin
    rst_in      = 1'b1;
    val_in      = 16'h0000;
    load_in     = 1'b0;
    digit_en_in = 4'hF;
    blank_lz_in = 1'b0;
    bright_in   = 4'hF;

    // Reset state and first digit after release
    step(3);
    check_val("rst_an", {28'd0, an_out}, 32'h0000000F);
    check_val("rst_seg", {25'd0, seg_out}, 32'h0000007F);
    check_val("rst_fd", {31'd0, frame_done_out}, 32'd0);
    rst_in = 1'b0;
    step(1);
    check_val("rel_an", {28'd0, an_out}, 32'h0000000E);
    check_val("rel_seg", {25'd0, seg_out}, 32'h00000040);
    step(20);
    check_val("mid_an", {28'd0, an_out}, 32'h0000000D);
    #2 rst_in = 1'b1;
    #1;
    check_val("async_an", {28'd0, an_out}, 32'h0000000F);
    check_val("async_seg", {25'd0, seg_out}, 32'h0000007F);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Scan of 1234
    load_val(16'h1234);
    step(3);
    wait_fd();
    check_val("s0_an", {28'd0, an_out}, 32'h0000000E);
    check_val("s0_seg", {25'd0, seg_out}, 32'h00000019);
    step(24);
    check_val("s1_an", {28'd0, an_out}, 32'h0000000D);
    check_val("s1_seg", {25'd0, seg_out}, 32'h00000030);
    step(16);
    check_val("s2_an", {28'd0, an_out}, 32'h0000000B);
    check_val("s2_seg", {25'd0, seg_out}, 32'h00000024);
    step(16);
    check_val("s3_an", {28'd0, an_out}, 32'h00000007);
    check_val("s3_seg", {25'd0, seg_out}, 32'h00000079);
    step(8);
    check_val("fd_64", {31'd0, frame_done_out}, 32'd1);
    step(1);
    check_val("fd_65", {31'd0, frame_done_out}, 32'd0);

    // Mid-frame load stays hidden until the next frame
    wait_fd();
    step(20);
    load_val(16'hAAAA);
    step(19);
    check_val("tear_d2", {25'd0, seg_out}, 32'h00000024);
    step(16);
    check_val("tear_d3", {25'd0, seg_out}, 32'h00000079);
    step(8);
    check_val("tear_fd", {31'd0, frame_done_out}, 32'd1);
    check_val("tear_new0", {25'd0, seg_out}, 32'h00000008);
    step(24);
    check_val("tear_new1_an", {28'd0, an_out}, 32'h0000000D);
    check_val("tear_new1", {25'd0, seg_out}, 32'h00000008);

    // Load on the wrap cycle is visible in the frame that starts right after
    step(38);
    load_val(16'h5678);
    step(1);
    check_val("wrapld_fd", {31'd0, frame_done_out}, 32'd1);
    check_val("wrapld_d0", {25'd0, seg_out}, 32'h00000000);
    step(16);
    check_val("wrapld_d1", {25'd0, seg_out}, 32'h00000078);

    // Leading-zero blanking
    blank_lz_in = 1'b1;
    load_val(16'h0050);
    step(3);
    wait_fd();
    check_val("lz_d0_an", {28'd0, an_out}, 32'h0000000E);
    check_val("lz_d0_seg", {25'd0, seg_out}, 32'h00000040);
    step(24);
    check_val("lz_d1_an", {28'd0, an_out}, 32'h0000000D);
    check_val("lz_d1_seg", {25'd0, seg_out}, 32'h00000012);
    step(16);
    check_val("lz_d2_an", {28'd0, an_out}, 32'h0000000F);
    check_val("lz_d2_seg", {25'd0, seg_out}, 32'h0000007F);
    step(16);
    check_val("lz_d3_an", {28'd0, an_out}, 32'h0000000F);
    load_val(16'h0000);
    step(3);
    wait_fd();
    check_val("lz0_d0_an", {28'd0, an_out}, 32'h0000000E);
    check_val("lz0_d0_seg", {25'd0, seg_out}, 32'h00000040);
    step(24);
    check_val("lz0_d1_an", {28'd0, an_out}, 32'h0000000F);
    blank_lz_in = 1'b0;

    // PWM duty
    bright_in = 4'h4;
    step(2);
    wait_fd();
    lit_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (an_out != 4'hF) lit_cnt++;
      step(1);
    end
    check_val("pwm4_lit", lit_cnt, 32'd4);
    check_val("pwm4_s1t0", {28'd0, an_out}, 32'h0000000D);
    step(4);
    check_val("pwm4_s1t4", {28'd0, an_out}, 32'h0000000F);
    bright_in = 4'h0;
    step(2);
    lit_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (an_out != 4'hF) lit_cnt++;
      step(1);
    end
    check_val("pwm0_lit", lit_cnt, 32'd0);
    bright_in = 4'hF;

    // Digit enables and one-hot-low anodes
    digit_en_in = 4'b0101;
    step(2);
    lit_cnt   = 0;
    multi_cnt = 0;
    off_cnt   = 0;
    for (int i = 0; i < 64; i++) begin
      if (an_out != 4'hF) lit_cnt++;
      if ($countones(~an_out) > 1) multi_cnt++;
      if (!an_out[1] || !an_out[3]) off_cnt++;
      step(1);
    end
    check_val("en_lit", lit_cnt, 32'd32);
    check_val("en_multi", multi_cnt, 32'd0);
    check_val("en_disabled", off_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
